// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface bus_rr_arbiter_if #(
  parameter int MASTER_CH = 4,
  parameter int IDX_W     = 2
);
  logic [MASTER_CH-1:0] m_req_;
  logic [MASTER_CH-1:0] m_grnt_;
  logic [IDX_W-1:0]     owner;
  logic                 owner_vld;
  logic                 timeout_err;

  modport master (output m_req_, input m_grnt_, owner, owner_vld, timeout_err);
  modport slave  (input m_req_, output m_grnt_, owner, owner_vld, timeout_err);
endinterface

// File: rtl/bus_rr_arbiter.sv
// Shared-bus arbiter: round-robin or fixed-priority grant among active-low requesters,
// back-to-back handover, optional watchdog that revokes an over-long ownership.
module bus_rr_arbiter #(
  parameter int MASTER_CH = 4,
  parameter int MODE      = 0,
  parameter int TIMEOUT   = 0,
  parameter int IDX_W     = (MASTER_CH > 1) ? $clog2(MASTER_CH) : 1
) (
  input logic             clk,
  input logic             reset,
  bus_rr_arbiter_if.slave bus
);
  // state   | meaning
  // ST_IDLE | nobody owns the bus, every grant high
  // ST_OWN  | owner_q holds the bus, its grant bit low
  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t               state_q, state_d;
  logic [MASTER_CH-1:0] grnt_q, grnt_d, cand;
  logic [IDX_W-1:0]     owner_q, owner_d, last_q, last_d, win_idx;
  logic                 terr_q, terr_d, win_vld, owner_req, wd_fire;

  assign owner_req = (state_q == ST_OWN) && !bus.m_req_[owner_q];

  // The watchdog offender is masked so the handover on a revoke skips it.
  assign cand = ~bus.m_req_ & ~({MASTER_CH{wd_fire}} & (MASTER_CH'(1) << owner_q));

  always_comb begin : sel
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= MASTER_CH; k++) begin
      if (MODE != 0) idx = k - 1;
      else           idx = (int'(last_q) + k) % MASTER_CH;
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int HW = $clog2(TIMEOUT + 1);
      logic [HW-1:0] hold_q;

      // Reaching TIMEOUT always revokes, so the count is cleared there and never needs to saturate.
      assign wd_fire = owner_req && (hold_q == HW'(TIMEOUT - 1));

      always_ff @(posedge clk or posedge reset) begin
        if (reset)                      hold_q <= '0;
        else if (owner_req && !wd_fire) hold_q <= hold_q + 1'b1;
        else                            hold_q <= '0;
      end
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    grnt_d  = grnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    terr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_OWN;
          owner_d = win_idx;
          last_d  = win_idx;
          grnt_d  = ~(MASTER_CH'(1) << win_idx);
        end
      end
      ST_OWN: begin
        if (!owner_req || wd_fire) begin
          terr_d = wd_fire;
          if (win_vld) begin
            owner_d = win_idx;
            last_d  = win_idx;
            grnt_d  = ~(MASTER_CH'(1) << win_idx);
          end else begin
            state_d = ST_IDLE;
            grnt_d  = '1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grnt_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grnt_q  <= '1;
      owner_q <= '0;
      last_q  <= IDX_W'(MASTER_CH - 1);
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.m_grnt_     = grnt_q;
  assign bus.owner       = owner_q;
  assign bus.owner_vld   = (state_q == ST_OWN);
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: RR, fixed-priority and watchdog instances against a rule-level model.
module tb_bus_rr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] req [3];
  logic [3:0] g   [3];
  logic [1:0] own [3];
  logic       vld [3];
  logic       terr[3];

  bus_rr_arbiter_if #(.MASTER_CH(4), .IDX_W(2)) if0 ();
  bus_rr_arbiter_if #(.MASTER_CH(4), .IDX_W(2)) if1 ();
  bus_rr_arbiter_if #(.MASTER_CH(4), .IDX_W(2)) if2 ();

  bus_rr_arbiter #(.MASTER_CH(4), .MODE(0), .TIMEOUT(0), .IDX_W(2)) dut_rr (.clk(clk), .reset(reset), .bus(if0));
  bus_rr_arbiter #(.MASTER_CH(4), .MODE(1), .TIMEOUT(0), .IDX_W(2)) dut_fp (.clk(clk), .reset(reset), .bus(if1));
  bus_rr_arbiter #(.MASTER_CH(4), .MODE(0), .TIMEOUT(8), .IDX_W(2)) dut_wd (.clk(clk), .reset(reset), .bus(if2));

  assign if0.m_req_ = req[0];
  assign if1.m_req_ = req[1];
  assign if2.m_req_ = req[2];
  assign g[0] = if0.m_grnt_;  assign own[0] = if0.owner;  assign vld[0] = if0.owner_vld;  assign terr[0] = if0.timeout_err;
  assign g[1] = if1.m_grnt_;  assign own[1] = if1.owner;  assign vld[1] = if1.owner_vld;  assign terr[1] = if1.timeout_err;
  assign g[2] = if2.m_grnt_;  assign own[2] = if2.owner;  assign vld[2] = if2.owner_vld;  assign terr[2] = if2.timeout_err;

  // Reference model: owner index (-1 = idle), last winner, OWN edges held, edges since grant.
  int cfg_mode[3] = '{0, 1, 0};
  int cfg_to  [3] = '{0, 0, 8};
  int m_own[3], m_last[3], m_hold[3], m_since[3];
  bit m_terr[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_own[d] = -1; m_last[d] = 3; m_hold[d] = 0; m_since[d] = 0; m_terr[d] = 0;
    end
  endtask

  function automatic int pick(input int d, input logic [3:0] r, input int excl);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (cfg_mode[d] != 0) ? k - 1 : (m_last[d] + k) % 4;
      if (idx != excl && r[idx] == 1'b0) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input int d);
    logic [3:0] r;
    int w, prev;
    r = req[d];
    prev = m_own[d];
    m_terr[d] = 0;
    if (m_own[d] < 0) begin
      w = pick(d, r, -1);
      if (w >= 0) begin m_own[d] = w; m_last[d] = w; m_hold[d] = 0; end
    end else if (r[m_own[d]]) begin
      w = pick(d, r, -1);
      m_own[d] = w;
      if (w >= 0) m_last[d] = w;
      m_hold[d] = 0;
    end else if (cfg_to[d] > 0 && m_hold[d] + 1 >= cfg_to[d]) begin
      m_terr[d] = 1;
      w = pick(d, r, m_own[d]);
      m_own[d] = w;
      if (w >= 0) m_last[d] = w;
      m_hold[d] = 0;
    end else begin
      m_hold[d]++;
    end
    if (m_own[d] != prev) m_since[d] = 0;
    else if (m_own[d] >= 0) m_since[d]++;
  endtask

  task automatic check_all();
    logic [3:0] eg;
    for (int d = 0; d < 3; d++) begin
      eg = 4'hF;
      if (m_own[d] >= 0) eg[m_own[d]] = 1'b0;
      chk($sformatf("d%0d_grnt", d), g[d], eg);
      chk($sformatf("d%0d_vld", d), vld[d], (m_own[d] >= 0) ? 1 : 0);
      chk($sformatf("d%0d_terr", d), terr[d], m_terr[d]);
      if (m_own[d] >= 0) chk($sformatf("d%0d_owner", d), own[d], m_own[d]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_all(input logic [3:0] r);
    for (int d = 0; d < 3; d++) req[d] = r;
  endtask

  // Each owner drops its request once it has held the bus h cycles, then re-requests.
  task automatic drive_hold(input logic [3:0] want, input int h);
    logic [3:0] r;
    for (int d = 0; d < 3; d++) begin
      r = want;
      if (m_own[d] >= 0 && m_since[d] >= h - 1) r[m_own[d]] = 1'b1;
      req[d] = r;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_grnt"}, g[d], 4'hF);
      chk({tag, "_vld"}, vld[d], 0);
      chk({tag, "_owner"}, own[d], 0);
      chk({tag, "_terr"}, terr[d], 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1 check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    set_all(4'b0000);
    model_reset();
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_vals("in_rst");
    end
    reset = 1'b0;

    // All request, each owner releases after 2 cycles: 0,1,2,3,0 with no gap.
    for (int n = 1; n <= 14; n++) begin
      drive_hold(4'b0000, 2);
      cycle();
      if (n <= 10) begin
        chk("rr_order", own[0], ((n - 1) / 2) % 4);
        chk("rr_nogap", vld[0], 1);
      end
    end

    // Fixed priority: 1 and 3 request together, both release after one cycle.
    set_all(4'b1111); cycle(); cycle();
    for (int i = 0; i < 10; i++) begin
      set_all((i % 2 == 0) ? 4'b0101 : 4'b1111);
      cycle();
      if (i % 2 == 0) chk("fp_win", g[1], 4'b1101);
      else            chk("fp_idle", vld[1], 0);
    end

    // Master 2 alone.
    set_all(4'b1111); cycle(); cycle();
    set_all(4'b1011);
    cycle();
    for (int d = 0; d < 3; d++) chk("solo_grnt", g[d], 4'b1011);
    cycle(); cycle();
    set_all(4'b1111);
    cycle();
    for (int d = 0; d < 3; d++) begin
      chk("solo_rel", g[d], 4'hF);
      chk("solo_vld", vld[d], 0);
    end

    // Watchdog: masters 0 and 1 hold requests forever.
    set_all(4'b1100);
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (n <= 8) begin
        chk("wd_hold", g[2], 4'b1110);
        chk("wd_quiet", terr[2], 0);
      end else if (n == 9) begin
        chk("wd_pulse", terr[2], 1);
        chk("wd_handover", g[2], 4'b1101);
      end else if (n == 10) begin
        chk("wd_pulse_end", terr[2], 0);
      end
    end

    // Reset asserted while master 1 owns the bus.
    set_all(4'b1111); cycle(); cycle();
    set_all(4'b1101); cycle(); cycle();
    for (int d = 0; d < 3; d++) chk("pre_rst_own", g[d], 4'b1101);
    #2 reset = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("async_rst_grnt", g[d], 4'hF);
      chk("async_rst_vld", vld[d], 0);
    end
    set_all(4'b1001);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Random request traffic, each bit flipping with low probability.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 3; d++) begin
        r = req[d];
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
        req[d] = r;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
